// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch stage: FSM states, buffer entry layout, buffer depth.
package fetch_pkg;
    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;
    localparam int BUF_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: imem request/response plus the decode valid/ready channel.
interface instr_fetch_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Two-entry FIFO of fetch entries; flush clears it, push and pop may coincide even when full.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   occ
);
    fetch_entry_t mem [BUF_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;

    // Callers only push when there is room after this cycle's pop, and only pop when non-empty.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-checked imem issue, next-PC mux, redirect flush with kill flag.
// Optional FETCH_HALT_EN: a fetched HALT_INSTR stops issue and adds the halted output.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int PC_STEP = 4
`ifdef FETCH_HALT_EN
    , parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}}
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_en,
    output logic [ADDR_W-1:0] next_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    instr_fetch_if.master     bus
`ifdef FETCH_HALT_EN
    , output logic            halted
`endif
);
    fetch_state_t      state, state_next;
    logic              inflight;
    logic              kill;
    logic [ADDR_W-1:0] pc_q;

    logic              run, redir, pop, push, credit_ok, issue, halt_hit;
    logic [2:0]        pend;
    logic [1:0]        occ;
    fetch_entry_t      head, push_entry;

    assign run   = (state == RUN) && !reset;
    assign redir = run && redirect_valid;

    assign bus.out_valid = (occ != 2'd0) && !redir && !reset;
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = inflight && !kill && !redir;

    // Entries already owed to the buffer after this cycle's dequeue must leave room for one more.
    assign pend      = 3'(occ) + 3'(inflight) - 3'(pop);
    assign credit_ok = pend < 3'(BUF_DEPTH);

`ifdef FETCH_HALT_EN
    assign halt_hit = push && (bus.imem_rdata == HALT_INSTR);
    assign halted   = (state == HALTED);
`else
    assign halt_hit = 1'b0;
`endif

    // A halt landing in the buffer blocks issue that same cycle so nothing trails it.
    assign issue = run && !redir && credit_ok && !halt_hit;

    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        next_pc    = '0;
        if (state == IDLE) state_next = RUN;
`ifdef FETCH_HALT_EN
        else if (state == RUN && halt_hit) state_next = HALTED;
`endif
        if (redir) begin
            pc_en   = 1'b1;
            next_pc = redirect_target;
        end else if (issue) begin
            pc_en   = 1'b1;
            next_pc = pc_in + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            inflight <= 1'b0;
            kill     <= 1'b0;
            pc_q     <= '0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            kill     <= redir;
            if (issue) pc_q <= pc_in;
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_in;

    assign push_entry = '{pc: pc_q, instr: bus.imem_rdata};

    fetch_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redir),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC register and 1-cycle imem models, scoreboard of issued fetches.
module tb_instr_fetch;
    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pc_in = '0;
    logic          pc_en;
    logic [AW-1:0] next_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_target = '0;
    logic [31:0]   halt_pc = 32'h3;
`ifdef FETCH_HALT_EN
    logic          halted;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic [AW-1:0] hold_pc;
    logic [IW-1:0] hold_instr;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .PC_STEP(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_en           (pc_en),
        .next_pc         (next_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .bus             (bus.master)
`ifdef FETCH_HALT_EN
        , .halted        (halted)
`endif
    );

    function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
        return (a == halt_pc) ? 32'hFFFF_FFFF : (a ^ 32'h5A00_0000);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // program_counter and synchronous imem
    always @(posedge clk) begin
        if (reset) pc_in <= '0;
        else if (pc_en) pc_in <= next_pc;
        if (bus.imem_req) bus.imem_rdata <= mem_data(bus.imem_addr);
    end

    // Scoreboard: every issue is owed exactly once, in order, unless a redirect or reset flushes it.
    always @(negedge clk) begin
        if (reset) q.delete();
        else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) check("spurious_out", 1, 0);
                else begin
                    e = q.pop_front();
                    check("sb_pc", bus.out_pc, e.pc);
                    check("sb_instr", bus.out_instr, e.instr);
                end
            end
`ifdef FETCH_HALT_EN
            if (redirect_valid && !halted) q.delete();
`else
            if (redirect_valid) q.delete();
`endif
            if (bus.imem_req) q.push_back('{bus.imem_addr, mem_data(bus.imem_addr)});
            check("credit", 64'(q.size() <= 2), 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.out_ready = 1'b1;
        // 1: reset values, one IDLE cycle, first issue
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_req", bus.imem_req, 0);
        check("rst_pc_en", pc_en, 0);
        check("rst_next_pc", next_pc, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_req", bus.imem_req, 0);
        check("idle_pc_en", pc_en, 0);
        @(negedge clk);
        check("t1_req", bus.imem_req, 1);
        check("t1_addr", bus.imem_addr, 0);
        check("t1_next_pc", next_pc, 4);
        check("t1_pc_en", pc_en, 1);

        // 2: one per cycle from two cycles after first issue
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", bus.out_valid, 1);
            check("t2_pc", bus.out_pc, 64'(4 * i));
            @(negedge clk);
        end

        // 3: backpressure
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        hold_pc    = bus.out_pc;
        hold_instr = bus.out_instr;
        repeat (6) @(negedge clk);
        check("t3_req", bus.imem_req, 0);
        check("t3_valid", bus.out_valid, 1);
        check("t3_hold_pc", bus.out_pc, hold_pc);
        check("t3_hold_instr", bus.out_instr, hold_instr);
        check("t3_owed", 64'(q.size()), 2);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);

        // 4: redirect with a response in flight and an entry buffered
        @(posedge clk); #1 bus.out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h100;
        @(negedge clk);
        check("t4_valid", bus.out_valid, 0);
        check("t4_req", bus.imem_req, 0);
        check("t4_pc_en", pc_en, 1);
        check("t4_next_pc", next_pc, 32'h100);
        @(posedge clk); #1 redirect_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        check("t4_issue", bus.imem_req, 1);
        check("t4_addr", bus.imem_addr, 32'h100);
        check("t4_flushed1", bus.out_valid, 0);
        @(negedge clk);
        check("t4_flushed2", bus.out_valid, 0);
        @(negedge clk);
        check("t4_valid2", bus.out_valid, 1);
        check("t4_first_pc", bus.out_pc, 32'h100);

        // 5: PC wrap, then reset mid-stream
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(posedge clk); #1 redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_addr", bus.imem_addr, 32'hFFFF_FFFC);
        check("t5_wrap", next_pc, 0);
        repeat (2) @(negedge clk);
        check("t5_pc_top", bus.out_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        check("t5_pc_zero", bus.out_pc, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_valid", bus.out_valid, 0);
        check("t5_rst_req", bus.imem_req, 0);
        check("t5_rst_pc_en", pc_en, 0);
        check("t5_rst_next_pc", next_pc, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_restart_valid", bus.out_valid, 1);
        check("t5_restart_pc", bus.out_pc, 0);
        repeat (4) @(negedge clk);

`ifdef FETCH_HALT_EN
        // 6: halt at pc 8
        @(posedge clk); #1 reset = 1'b1; halt_pc = 32'h8;
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 20 && !halted; k++) @(negedge clk);
        check("t6_halted", halted, 1);
        repeat (3) begin
            @(negedge clk);
            check("t6_noreq", bus.imem_req, 0);
        end
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_target = 32'h200;
        @(negedge clk);
        check("t6_redir_pc_en", pc_en, 0);
        check("t6_redir_req", bus.imem_req, 0);
        @(posedge clk); #1 redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_still_halted", halted, 1);
        check("t6_drained", 64'(q.size()), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
